// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: bundles the loader handshake and the processor-facing issue signals.
//   ld_valid / ld_data / ld_ready : loader pushes 32-bit instruction words into the queue
//   hold                          : processor stall, freezes the current issue window
//   instruction / instr_valid / pc: instruction currently presented to the processor
//   halted                        : a halt instruction has finished its issue window
// Modports: master = loader/processor side, slave = the fetch queue.
interface instr_fetch_queue_if;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        hold;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic        halted;

  modport master (
    output ld_valid, ld_data, hold,
    input  ld_ready, instruction, instr_valid, pc, halted
  );

  modport slave (
    input  ld_valid, ld_data, hold,
    output ld_ready, instruction, instr_valid, pc, halted
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: FIFO of instruction words feeding a timed issue window.
// Each popped word is presented for ISSUE_CYCLES un-held clocks. A word whose opcode
// (bits [31:26]) equals HALT_OP parks the queue in a terminal halted state at the end
// of its window; only reset leaves it.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : instr_fetch_queue_if.slave (loader handshake + issue outputs)
module instr_fetch_queue #(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned ISSUE_CYCLES = 2,
  parameter logic [5:0]  HALT_OP      = 6'h3F
) (
  input logic                  clk,
  input logic                  reset,
  instr_fetch_queue_if.slave   bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [3:0]  LastCnt = 4'(ISSUE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StHalt} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q, count_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic              halted_q, halted_d;
  // Set once the first word has issued; the first word gets pc 0, later ones pc+1.
  logic              issued_q, issued_d;
  logic              push, pop, ld_ready;

  // Registered count only: a same-cycle pop does not open a slot for the loader.
  assign ld_ready = (count_q < CntW'(DEPTH));
  assign push     = bus.ld_valid && ld_ready;

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    pop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        valid_d = 1'b0;
        if (count_q != '0 && !bus.hold) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!bus.hold) begin
          if (cnt_q == LastCnt) begin
            if (instr_q[31:26] == HALT_OP) begin
              state_d  = StHalt;
              valid_d  = 1'b0;
              halted_d = 1'b1;
            end else if (count_q != '0) begin
              pop = 1'b1;  // back-to-back issue, stay in StIssue
            end else begin
              state_d = StIdle;
              valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: state_d = StIdle;
    endcase

    if (pop) begin
      instr_d  = mem_q[rd_ptr_q];
      valid_d  = 1'b1;
      cnt_d    = '0;
      pc_d     = issued_q ? pc_q + 32'd1 : 32'd0;
      issued_d = 1'b1;
    end
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      pc_q     <= '0;
      halted_q <= 1'b0;
      issued_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      halted_q <= halted_d;
      issued_q <= issued_d;
      if (push) begin
        mem_q[wr_ptr_q] <= bus.ld_data;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.instruction = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.pc          = pc_q;
  assign bus.halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  localparam int unsigned IC = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_queue_if bus();

  instr_fetch_queue #(
    .DEPTH(4),
    .ISSUE_CYCLES(IC),
    .HALT_OP(6'h3F)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] next_pc;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a word the bench knows will be accepted on the next edge; record its expected pc.
  task automatic push_drive(input logic [31:0] w);
    bus.ld_valid = 1'b1;
    bus.ld_data  = w;
    sb.push_back('{w, next_pc});
    next_pc++;
  endtask

  task automatic check_front(input string tag);
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed issue expected empty scoreboard", tag);
    end else begin
      chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
      chk({tag, "_instr"}, bus.instruction, sb[0].word);
      chk({tag, "_pc"}, bus.pc, sb[0].pc);
    end
  endtask

  task automatic retire();
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  // Checks the presented word for a full un-held window, ending on the window-end edge.
  task automatic run_window(input string tag);
    for (int i = 0; i < int'(IC); i++) begin
      check_front(tag);
      tick();
    end
    retire();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.hold     = 1'b0;
    sb.delete();
    next_pc = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values
    do_reset();
    chk("rst_instr", bus.instruction, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_ready", 32'(bus.ld_ready), 32'd1);

    // Three back-to-back words, continuous issue, then idle holding last word
    push_drive(32'h28200008);
    tick();
    chk("t1_lat", 32'(bus.instr_valid), 32'd0);
    push_drive(32'h2840000B);
    tick();
    check_front("t1_w0a");
    push_drive(32'h54220000);
    tick();
    bus.ld_valid = 1'b0;
    check_front("t1_w0b");
    tick();
    retire();
    run_window("t1_w1");
    run_window("t1_w2");
    chk("t1_idle_valid", 32'(bus.instr_valid), 32'd0);
    chk("t1_idle_instr", bus.instruction, 32'h54220000);
    tick();
    chk("t1_idle_valid2", 32'(bus.instr_valid), 32'd0);

    // Fill under hold, fifth word refused, order preserved
    do_reset();
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_drive(32'h10000000 + 32'(i));
      tick();
      chk("t2_ready", 32'(bus.ld_ready), (i == 3) ? 32'd0 : 32'd1);
    end
    bus.ld_data = 32'hDEAD0005;
    tick();
    chk("t2_full_ready", 32'(bus.ld_ready), 32'd0);
    chk("t2_full_valid", 32'(bus.instr_valid), 32'd0);
    bus.ld_valid = 1'b0;
    bus.hold     = 1'b0;
    tick();
    chk("t2_ready_after_pop", 32'(bus.ld_ready), 32'd1);
    for (int i = 0; i < 4; i++) run_window("t2_issue");
    chk("t2_end_valid", 32'(bus.instr_valid), 32'd0);
    chk("t2_end_instr", bus.instruction, 32'h10000003);

    // Hold during issue of the second word stretches its window to five cycles
    do_reset();
    push_drive(32'h28200008);
    tick();
    push_drive(32'h2840000B);
    tick();
    bus.ld_valid = 1'b0;
    run_window("t3_w0");
    check_front("t3_w1_start");
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_front("t3_w1_held");
    end
    bus.hold = 1'b0;
    tick();
    check_front("t3_w1_last");
    tick();
    retire();
    chk("t3_end_valid", 32'(bus.instr_valid), 32'd0);

    // Halt opcode terminates issue; later word never issued, loads still accepted
    do_reset();
    push_drive(32'h28200008);
    tick();
    push_drive(32'hFC000000);
    tick();
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'h28200008;
    check_front("t4_w0a");
    tick();
    bus.ld_valid = 1'b0;
    check_front("t4_w0b");
    tick();
    retire();
    run_window("t4_halt");
    for (int i = 0; i < 3; i++) begin
      chk("t4_halted", 32'(bus.halted), 32'd1);
      chk("t4_valid", 32'(bus.instr_valid), 32'd0);
      chk("t4_pc", bus.pc, 32'd1);
      chk("t4_instr", bus.instruction, 32'hFC000000);
      tick();
    end
    bus.ld_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_data = 32'h30000000 + 32'(i);
      tick();
      chk("t4_halt_ready", 32'(bus.ld_ready), (i == 2) ? 32'd0 : 32'd1);
    end
    bus.ld_valid = 1'b0;
    tick();
    chk("t4_still_halted", 32'(bus.halted), 32'd1);
    chk("t4_no_issue", 32'(bus.instr_valid), 32'd0);

    // Asynchronous reset mid-window of second word with two words queued
    do_reset();
    push_drive(32'h40000001);
    tick();
    push_drive(32'h40000002);
    tick();
    push_drive(32'h40000003);
    tick();
    push_drive(32'h40000004);
    tick();
    retire();
    bus.ld_valid = 1'b0;
    check_front("t5_w1");
    #3;
    reset = 1'b1;
    #1;
    chk("t5_rst_instr", bus.instruction, 32'h0);
    chk("t5_rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("t5_rst_pc", bus.pc, 32'h0);
    chk("t5_rst_ready", 32'(bus.ld_ready), 32'd1);
    #1;
    reset = 1'b0;
    sb.delete();
    next_pc = '0;
    push_drive(32'h50000001);
    tick();
    bus.ld_valid = 1'b0;
    tick();
    run_window("t5_after");
    chk("t5_end_valid", 32'(bus.instr_valid), 32'd0);

    // Full queue: pop refuses the stalled word, then push coincides with a pop
    do_reset();
    bus.hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_drive(32'h60000000 + 32'(i));
      tick();
    end
    bus.ld_data = 32'hDEAD0006;
    bus.hold    = 1'b0;
    tick();
    bus.ld_valid = 1'b0;
    chk("t6_ready_after_pop", 32'(bus.ld_ready), 32'd1);
    check_front("t6_a0");
    tick();
    check_front("t6_a1");
    push_drive(32'h6000000E);
    tick();
    retire();
    bus.ld_valid = 1'b0;
    chk("t6_ready_pushpop", 32'(bus.ld_ready), 32'd1);
    for (int i = 0; i < 4; i++) run_window("t6_issue");
    chk("t6_end_valid", 32'(bus.instr_valid), 32'd0);
    chk("t6_end_instr", bus.instruction, 32'h6000000E);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
